// File: rtl/rv_pkg.sv
// Shared RISC-V datapath definitions for the fpga-core integer pipeline.
package rv_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage : rv_pkg

// File: rtl/rv_regfile_rdport.sv
// One register-file read port: write-first bypass, x0 zeroing and the
// registered output stage.
module rv_regfile_rdport
  import rv_pkg::*;
#(
  parameter int DATA_W      = XLEN,
  parameter int ADDR_W      = REG_ADDR_W,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_sel,
  input  logic [DATA_W-1:0] i_reg_val,
  input  logic              i_byp_en,
  input  logic [ADDR_W-1:0] i_wsel,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_next;
  logic [DATA_W-1:0] r_rdata;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = i_reg_val;
    if (i_byp_en && (i_wsel == i_sel)) begin
      w_next = i_wdata;
    end
    if (ZERO_REG_EN && (i_sel == '0)) begin
      w_next = '0;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_next;
    end
  end

  assign o_rdata = r_rdata;

endmodule : rv_regfile_rdport

// File: rtl/rv_regfile_2r1w.sv
// Integer register file: 2 synchronous read ports with write-first bypass,
// 1 write port, optional hardwired-zero x0.
module rv_regfile_2r1w
  import rv_pkg::*;
#(
  parameter int DATA_W      = XLEN,
  parameter int NUM_REGS    = NUM_ARCH_REGS,
  parameter int ADDR_W      = REG_ADDR_W,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rsel1,
  input  logic [ADDR_W-1:0] rsel2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] wsel,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_ok;
  logic              w_wsel_valid;
  logic [DATA_W-1:0] w_raw1;
  logic [DATA_W-1:0] w_raw2;

  // A write lands only on an implemented, non-hardwired register; the same
  // qualifier gates the read bypass so dropped writes are never forwarded.
  always_comb begin
    w_wsel_valid = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wsel == ADDR_W'(i)) begin
        w_wsel_valid = 1'b1;
      end
    end
    w_wr_ok = wen && w_wsel_valid && !(ZERO_REG_EN && (wsel == '0));
  end

  // Unimplemented indices fall through to the zero default.
  always_comb begin
    w_raw1 = '0;
    w_raw2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsel1 == ADDR_W'(i)) w_raw1 = r_regs[i];
      if (rsel2 == ADDR_W'(i)) w_raw2 = r_regs[i];
    end
  end

  // NOTE: the storage array is reset like any other flop so no X can ever be
  // read out; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ok && (wsel == ADDR_W'(i))) begin
          r_regs[i] <= wdata;
        end
      end
    end
  end

  rv_regfile_rdport #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_rdport1 (
    .clk       (clk),
    .rst       (rst),
    .i_sel     (rsel1),
    .i_reg_val (w_raw1),
    .i_byp_en  (w_wr_ok),
    .i_wsel    (wsel),
    .i_wdata   (wdata),
    .o_rdata   (rdata1)
  );

  rv_regfile_rdport #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_rdport2 (
    .clk       (clk),
    .rst       (rst),
    .i_sel     (rsel2),
    .i_reg_val (w_raw2),
    .i_byp_en  (w_wr_ok),
    .i_wsel    (wsel),
    .i_wdata   (wdata),
    .o_rdata   (rdata2)
  );

endmodule : rv_regfile_2r1w

// File: tb/tb_rv_regfile_2r1w.sv
// Scoreboard bench for rv_regfile_2r1w: expected read data is queued when
// stimulus is driven and compared one edge later.
module tb_rv_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic        wen;

  rv_regfile_2r1w dut (
    .clk    (clk),
    .rst    (rst),
    .rsel1  (rsel1),
    .rsel2  (rsel2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .wsel   (wsel),
    .wdata  (wdata),
    .wen    (wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_val(input logic [4:0] s, input logic [4:0] ws,
                                            input logic [31:0] wd, input logic we);
    if (s == 5'd0) return 32'h0;
    if (we && ws == s) return wd;
    return m_regs[s];
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue the expected reads.
  task automatic drive(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] ws, input logic [31:0] wd, input logic we);
    exp_t e;
    @(negedge clk);
    rsel1 = r1; rsel2 = r2; wsel = ws; wdata = wd; wen = we;
    e.tag = tag;
    e.e1  = model_val(r1, ws, wd, we);
    e.e2  = model_val(r2, ws, wd, we);
    sb_q.push_back(e);
    if (we && ws != 5'd0) m_regs[ws] = wd;
  endtask

  task automatic settle();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_rd1"}, rdata1, e.e1);
      check({e.tag, "_rd2"}, rdata2, e.e2);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] ws, input logic [31:0] wd, input logic we);
    drive(tag, r1, r2, ws, wd, we);
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    rsel1 = 5'd3; rsel2 = 5'd3;
    wsel = 5'd3; wdata = 32'hFFFF_FFFF; wen = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

    // Writes attempted across edges while reset is held must be ignored.
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_rd1", rdata1, 32'h0);
    check("in_reset_rd2", rdata2, 32'h0);
    @(negedge clk);
    wen = 1'b0;
    rst = 1'b1;

    step("rst_r3", 5'd3, 5'd3, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step($sformatf("rst_sweep%0d", i), 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);
    end

    step("wr5",   5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 1'b1);
    step("idle",  5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    step("rd5",   5'd5, 5'd5, 5'd0, 32'h0, 1'b0);

    step("wr10",  5'd10, 5'd15, 5'd10, 32'h1234_5678, 1'b1);
    step("wr15",  5'd10, 5'd15, 5'd15, 32'hAAAA_AAAA, 1'b1);
    step("rd10_15", 5'd10, 5'd15, 5'd0, 32'h0, 1'b0);

    // Outputs must hold through a mid-cycle write until the next edge.
    drive("byp15", 5'd10, 5'd15, 5'd15, 32'h0000_0001, 1'b1);
    #2;
    check("hold_before_edge", rdata2, 32'hAAAA_AAAA);
    rsel2 = 5'd10;
    wdata = 32'h0000_0001;
    #1;
    check("hold_sel_change", rdata2, 32'hAAAA_AAAA);
    rsel2 = 5'd15;
    settle();
    step("keep15", 5'd10, 5'd15, 5'd0, 32'h0, 1'b0);

    step("zero_wr", 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    step("zero_rd", 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

    step("indep",  5'd5, 5'd10, 5'd20, 32'hCAFE_F00D, 1'b1);
    step("rd20",   5'd20, 5'd20, 5'd0, 32'h0, 1'b0);
    step("wr31",   5'd31, 5'd1, 5'd31, 32'h8000_0001, 1'b1);
    step("load",   5'd5, 5'd15, 5'd0, 32'h0, 1'b0);

    // Asynchronous reset between edges, with a write pending on the next edge.
    @(negedge clk);
    rsel1 = 5'd5; rsel2 = 5'd15; wsel = 5'd5; wdata = 32'h5555_5555; wen = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_rd1", rdata1, 32'h0);
    check("async_rst_rd2", rdata2, 32'h0);
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    @(posedge clk);
    #1;
    check("rst_edge_rd1", rdata1, 32'h0);
    @(negedge clk);
    wen = 1'b0;
    rst = 1'b1;

    step("post_rst", 5'd5, 5'd15, 5'd0, 32'h0, 1'b0);
    step("post_rst31", 5'd31, 5'd20, 5'd0, 32'h0, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rv_regfile_2r1w
